bp_cfg_seq_loader: RTL and testbench
====================================

Name:
bp_cfg_seq_loader

Overview:
- Boot-time configuration sequencer for a BlackParrot processor instance.
- Walks every core tile (count derived from the active bp_proc_param_s) and issues an ordered series of config-bus writes: freeze, core id, cache modes, CCE mode.
- Once every write is acknowledged, it unfreezes all cores.
- Sits between the IO complex and the per-tile config links; it is the sole master of the config bus until done_o.

Parameters:
num_core_p, 1, number of cores (cc_x_dim*cc_y_dim); legal 1..64
cfg_addr_width_p, 20, config-bus address width
cfg_data_width_p, 64, config-bus data width
max_credits_p, 4, max outstanding unacknowledged writes; legal 1..15
icache_mode_p, 1, value written to the icache mode register
dcache_mode_p, 1, value written to the dcache mode register
cce_mode_p, 1, value written to the CCE mode register (0 uncached, 1 normal)
boot_pc_p, 0x80000000, start PC value (used only with the optional feature)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
restart_i  in  1  pulse; re-runs the full sequence when idle in DONE
cfg_v_o  out  1  write valid
cfg_ready_i  in  1  write accepted when cfg_v_o&cfg_ready_i
cfg_core_o  out  clog2(num_core_p) (min 1)  target core index
cfg_addr_o  out  cfg_addr_width_p  register address
cfg_data_o  out  cfg_data_width_p  write data
resp_v_i  in  1  one write acknowledged (one pulse per ack)
busy_o  out  1  sequence in progress
done_o  out  1  all cores unfrozen and all acks received
cfg_error_o  out  1  sticky; ack received with zero outstanding

Behaviour:
- Async reset (reset_n_i low) sets: state=CFG; core counter=0; step=0; credits=0; cfg_v_o=0; busy_o=0; done_o=0; cfg_error_o=0. Outputs are registered.
- The sequence starts automatically on the first clock edge after reset deassertion. busy_o=1 from that cycle.
- States: CFG -> DRAIN1 -> UNFREEZE -> DRAIN2 -> DONE.
- CFG, per core c in ascending order, steps:
  - FREEZE: addr 0x00002, data 1
  - CORE_ID: addr 0x00004, data c
  - ICACHE: addr 0x00010, data icache_mode_p
  - DCACHE: addr 0x00018, data dcache_mode_p
  - CCE: addr 0x00020, data cce_mode_p
- A step advances only on a fire (cfg_v_o&cfg_ready_i).
- After core num_core_p-1 step CCE fires, go to DRAIN1.
- DRAIN1: cfg_v_o=0; wait until credits==0, then go to UNFREEZE with the core counter cleared.
- UNFREEZE: one write per core (addr 0x00002, data 0), ascending order. The last fire goes to DRAIN2.
- DRAIN2: wait until credits==0, then go to DONE. done_o=1 and busy_o=0 in DONE.
- cfg_v_o=1 in CFG/UNFREEZE only when credits<max_credits_p.
- Once asserted, cfg_v_o and its payload stay stable until the fire.
- Credit counter: +1 on fire, -1 on resp_v_i; unchanged when both occur in the same cycle.
- resp_v_i with credits==0 and no same-cycle fire: counter stays 0 and cfg_error_o is set (sticky; cleared only by reset).
- restart_i in DONE: next cycle the state returns to CFG with counters cleared, done_o=0 and busy_o=1. restart_i in any other state is ignored.
- Reset mid-sequence: all state is discarded and the sequence restarts from core 0. Outstanding acks are not tracked across reset.
- Address and data are zero-extended to port width.

Optional Feature:
- Macro: BP_CFG_SEQ_LOADER_NPC_EN.
- When defined: CFG adds a sixth step per core, NPC: addr 0x00040, data boot_pc_p, issued after CCE.
- When undefined: five steps per core; address 0x00040 is never driven.

Decomposition:
- Shared package (bp_common_cfg_link_pkg): the config register address localparams (freeze, core_id, icache_mode, dcache_mode, cce_mode, npc), the state enum, and the step enum.
- One sub-module: bp_cfg_credit_counter, an up/down saturating credit counter with error flag. Everything else stays inline.

Test Plan:
1. num_core_p=2, max_credits_p=2, cfg_ready_i=1, resp_v_i one cycle after each fire -> writes, in order:
   - core0: (0,0x2,1), (0,0x4,0), (0,0x10,1), (0,0x18,1), (0,0x20,1)
   - core1: the same five writes with core_id data 1
   - then (0,0x2,0), (1,0x2,0)
   - done_o=1 two cycles after the last ack.
2. Acks withheld -> exactly 2 writes fire, then cfg_v_o=0. One resp_v_i pulse -> cfg_v_o returns the next cycle with the third write unchanged.
3. cfg_ready_i toggles 0/1 randomly -> payload stable while valid and not ready. Total fires = 12 with num_core_p=2, or 14 with NPC_EN.
4. resp_v_i pulse right after reset -> cfg_error_o=1 and stays 1; the sequence still completes.
5. In DONE, pulse restart_i -> busy_o=1 and done_o=0 next cycle; the full 12-write sequence repeats.
6. reset_n_i low asynchronously during the core1 ICACHE step -> outputs clear immediately; after release the sequence restarts at (0,0x2,1).

Source files
------------

// File: rtl/bp_common_cfg_link_pkg.sv
// Config-link definitions shared by the boot config sequencer: register map, FSM states and write steps.
// BP_CFG_SEQ_LOADER_NPC_EN selects whether the NPC step closes each core's write series.
package bp_common_cfg_link_pkg;

    localparam int unsigned CFG_REG_ADDR_W = 20;
    localparam int unsigned CREDIT_W       = 4;

    localparam logic [CFG_REG_ADDR_W-1:0] CFG_ADDR_FREEZE      = 20'h00002;
    localparam logic [CFG_REG_ADDR_W-1:0] CFG_ADDR_CORE_ID     = 20'h00004;
    localparam logic [CFG_REG_ADDR_W-1:0] CFG_ADDR_ICACHE_MODE = 20'h00010;
    localparam logic [CFG_REG_ADDR_W-1:0] CFG_ADDR_DCACHE_MODE = 20'h00018;
    localparam logic [CFG_REG_ADDR_W-1:0] CFG_ADDR_CCE_MODE    = 20'h00020;
    localparam logic [CFG_REG_ADDR_W-1:0] CFG_ADDR_NPC         = 20'h00040;

    typedef enum logic [2:0] {
        ST_CFG,
        ST_DRAIN1,
        ST_UNFREEZE,
        ST_DRAIN2,
        ST_DONE
    } cfg_state_e;

    typedef enum logic [2:0] {
        STEP_FREEZE,
        STEP_CORE_ID,
        STEP_ICACHE,
        STEP_DCACHE,
        STEP_CCE,
        STEP_NPC
    } cfg_step_e;

`ifdef BP_CFG_SEQ_LOADER_NPC_EN
    localparam cfg_step_e LAST_STEP = STEP_NPC;
`else
    localparam cfg_step_e LAST_STEP = STEP_CCE;
`endif

    // Register address written by each per-core step.
    function automatic logic [CFG_REG_ADDR_W-1:0] step_addr(input cfg_step_e step);
        logic [CFG_REG_ADDR_W-1:0] addr;
        case (step)
            STEP_FREEZE:  addr = CFG_ADDR_FREEZE;
            STEP_CORE_ID: addr = CFG_ADDR_CORE_ID;
            STEP_ICACHE:  addr = CFG_ADDR_ICACHE_MODE;
            STEP_DCACHE:  addr = CFG_ADDR_DCACHE_MODE;
            STEP_CCE:     addr = CFG_ADDR_CCE_MODE;
            STEP_NPC:     addr = CFG_ADDR_NPC;
            default:      addr = CFG_ADDR_FREEZE;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Up/down saturating count of unacknowledged config writes, with a sticky flag for acks that arrive
// when nothing is outstanding.
module bp_cfg_credit_counter
    import bp_common_cfg_link_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [CREDIT_W-1:0] o_count,
    output logic [CREDIT_W-1:0] o_count_next_c,
    output logic                o_error
);

    logic [CREDIT_W-1:0] r_count;
    logic                r_error;
    logic [CREDIT_W-1:0] w_count_next;
    logic                w_error_set;

    // Simultaneous inc and dec cancel; an underflowing dec is flagged instead of wrapping.
    always_comb begin
        w_count_next = r_count;
        w_error_set  = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_count != '1) begin
                w_count_next = r_count + CREDIT_W'(1);
            end
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                w_error_set = 1'b1;
            end else begin
                w_count_next = r_count - CREDIT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_error <= r_error | w_error_set;
        end
    end

    assign o_count        = r_count;
    assign o_count_next_c = w_count_next;
    assign o_error        = r_error;

endmodule

// File: rtl/bp_cfg_seq_loader.sv
// Boot-time config sequencer: freezes and configures every core tile over the config bus, then unfreezes them.
// Define BP_CFG_SEQ_LOADER_NPC_EN to add a boot-PC (NPC) write after the CCE mode write of each core.
module bp_cfg_seq_loader
    import bp_common_cfg_link_pkg::*;
#(
`ifdef BP_CFG_SEQ_LOADER_NPC_EN
    parameter logic [63:0] boot_pc_p        = 64'h0000_0000_8000_0000,
`endif
    parameter int unsigned num_core_p       = 1,
    parameter int unsigned cfg_addr_width_p = 20,
    parameter int unsigned cfg_data_width_p = 64,
    parameter int unsigned max_credits_p    = 4,
    parameter int unsigned icache_mode_p    = 1,
    parameter int unsigned dcache_mode_p    = 1,
    parameter int unsigned cce_mode_p       = 1,
    localparam int unsigned core_w_lp       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        restart_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_w_lp-1:0]        cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        resp_v_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        cfg_error_o
);

    localparam int unsigned AW = cfg_addr_width_p;
    localparam int unsigned DW = cfg_data_width_p;
    localparam logic [core_w_lp-1:0] LAST_CORE = core_w_lp'(num_core_p - 1);

    cfg_state_e           r_state, w_state_next;
    cfg_step_e            r_step, w_step_next;
    logic [core_w_lp-1:0] r_core, w_core_next;
    logic                 r_v, w_v_next;
    logic [core_w_lp-1:0] r_core_out, w_core_out_next;
    logic [AW-1:0]        r_addr, w_addr_next;
    logic [DW-1:0]        r_data, w_data_next;
    logic                 r_busy, w_busy_next;
    logic                 r_done, w_done_next;
    logic                 w_fire;
    logic [CREDIT_W-1:0]  w_credits, w_credits_next;

    assign w_fire = r_v & cfg_ready_i;

    bp_cfg_credit_counter u_credits (
        .i_clk          (clk_i),
        .i_reset_n      (reset_n_i),
        .i_inc          (w_fire),
        .i_dec          (resp_v_i),
        .o_count        (w_credits),
        .o_count_next_c (w_credits_next),
        .o_error        (cfg_error_o)
    );

    // Next state plus the registered write presented on the bus in the following cycle.
    always_comb begin
        w_state_next    = r_state;
        w_step_next     = r_step;
        w_core_next     = r_core;
        w_v_next        = 1'b0;
        w_core_out_next = r_core_out;
        w_addr_next     = r_addr;
        w_data_next     = r_data;
        w_busy_next     = 1'b1;
        w_done_next     = 1'b0;

        case (r_state)
            ST_CFG: begin
                if (w_fire) begin
                    if (r_step == LAST_STEP) begin
                        w_step_next = STEP_FREEZE;
                        if (r_core == LAST_CORE) begin
                            w_state_next = ST_DRAIN1;
                            w_core_next  = '0;
                        end else begin
                            w_core_next = r_core + core_w_lp'(1);
                        end
                    end else begin
                        w_step_next = cfg_step_e'(r_step + 3'd1);
                    end
                end
            end
            ST_DRAIN1: begin
                if (w_credits == '0) begin
                    w_state_next = ST_UNFREEZE;
                    w_core_next  = '0;
                end
            end
            ST_UNFREEZE: begin
                if (w_fire) begin
                    if (r_core == LAST_CORE) begin
                        w_state_next = ST_DRAIN2;
                        w_core_next  = '0;
                    end else begin
                        w_core_next = r_core + core_w_lp'(1);
                    end
                end
            end
            ST_DRAIN2: begin
                if (w_credits == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (restart_i) begin
                    w_state_next = ST_CFG;
                    w_core_next  = '0;
                    w_step_next  = STEP_FREEZE;
                end
            end
            default: begin
                w_state_next = ST_CFG;
                w_core_next  = '0;
                w_step_next  = STEP_FREEZE;
            end
        endcase

        w_busy_next = (w_state_next != ST_DONE);
        w_done_next = (w_state_next == ST_DONE);

        // Indices only move on a fire, so a stalled write keeps an identical payload.
        if ((w_state_next == ST_CFG || w_state_next == ST_UNFREEZE) &&
            (w_credits_next < CREDIT_W'(max_credits_p))) begin
            w_v_next = 1'b1;
        end

        w_core_out_next = w_core_next;
        if (w_state_next == ST_UNFREEZE) begin
            w_addr_next = AW'(CFG_ADDR_FREEZE);
            w_data_next = '0;
        end else begin
            w_addr_next = AW'(step_addr(w_step_next));
            case (w_step_next)
                STEP_FREEZE:  w_data_next = DW'(1);
                STEP_CORE_ID: w_data_next = DW'(w_core_next);
                STEP_ICACHE:  w_data_next = DW'(icache_mode_p);
                STEP_DCACHE:  w_data_next = DW'(dcache_mode_p);
                STEP_CCE:     w_data_next = DW'(cce_mode_p);
`ifdef BP_CFG_SEQ_LOADER_NPC_EN
                STEP_NPC:     w_data_next = DW'(boot_pc_p);
`endif
                default:      w_data_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= ST_CFG;
            r_step     <= STEP_FREEZE;
            r_core     <= '0;
            r_v        <= 1'b0;
            r_core_out <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_step     <= w_step_next;
            r_core     <= w_core_next;
            r_v        <= w_v_next;
            r_core_out <= w_core_out_next;
            r_addr     <= w_addr_next;
            r_data     <= w_data_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign cfg_v_o    = r_v;
    assign cfg_core_o = r_core_out;
    assign cfg_addr_o = r_addr;
    assign cfg_data_o = r_data;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule

// File: tb/tb_bp_cfg_seq_loader.sv
// Self-checking bench for bp_cfg_seq_loader (2 cores, 2 credits) against a write-list reference model.
// Build with BP_CFG_SEQ_LOADER_NPC_EN defined to exercise the NPC step.
module tb_bp_cfg_seq_loader;

    localparam int NC   = 2;
    localparam int MAXC = 2;
    localparam int AW   = 20;
    localparam int DW   = 64;
    localparam logic [63:0] BOOT = 64'h0000_0000_8000_0000;
`ifdef BP_CFG_SEQ_LOADER_NPC_EN
    localparam int STEPS = 6;
`else
    localparam int STEPS = 5;
`endif
    localparam int TOTAL = NC * STEPS + NC;

    typedef struct {
        logic          core;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          restart_i;
    logic          cfg_v_o;
    logic          cfg_ready_i;
    logic [0:0]    cfg_core_o;
    logic [AW-1:0] cfg_addr_o;
    logic [DW-1:0] cfg_data_o;
    logic          resp_v_i;
    logic          busy_o;
    logic          done_o;
    logic          cfg_error_o;

    always #5 clk = ~clk;

    bp_cfg_seq_loader #(
`ifdef BP_CFG_SEQ_LOADER_NPC_EN
        .boot_pc_p        (BOOT),
`endif
        .num_core_p       (NC),
        .cfg_addr_width_p (AW),
        .cfg_data_width_p (DW),
        .max_credits_p    (MAXC),
        .icache_mode_p    (1),
        .dcache_mode_p    (1),
        .cce_mode_p       (1)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n_i),
        .restart_i   (restart_i),
        .cfg_v_o     (cfg_v_o),
        .cfg_ready_i (cfg_ready_i),
        .cfg_core_o  (cfg_core_o),
        .cfg_addr_o  (cfg_addr_o),
        .cfg_data_o  (cfg_data_o),
        .resp_v_i    (resp_v_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cfg_error_o (cfg_error_o)
    );

    wr_t          exp_q[$];
    int           idx, outstanding, fires, cyc, last_rsp_cyc;
    bit           err_exp, stall;
    logic [127:0] stall_pl;
    int           n_checks = 0;
    int           n_err    = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [127:0] bus_pl();
        return 128'({cfg_core_o, cfg_addr_o, cfg_data_o});
    endfunction

    function automatic logic [127:0] wr_pl(input wr_t w);
        return 128'({w.core, w.addr, w.data});
    endfunction

    // Ordered write list derived directly from the register-programming rules.
    task automatic build_expected();
        wr_t w;
        exp_q.delete();
        for (int c = 0; c < NC; c++) begin
            w.core = 1'(c);
            w.addr = 20'h00002; w.data = 64'd1;         exp_q.push_back(w);
            w.addr = 20'h00004; w.data = 64'(c);        exp_q.push_back(w);
            w.addr = 20'h00010; w.data = 64'd1;         exp_q.push_back(w);
            w.addr = 20'h00018; w.data = 64'd1;         exp_q.push_back(w);
            w.addr = 20'h00020; w.data = 64'd1;         exp_q.push_back(w);
`ifdef BP_CFG_SEQ_LOADER_NPC_EN
            w.addr = 20'h00040; w.data = BOOT;          exp_q.push_back(w);
`endif
        end
        for (int c = 0; c < NC; c++) begin
            w.core = 1'(c); w.addr = 20'h00002; w.data = 64'd0;
            exp_q.push_back(w);
        end
    endtask

    task automatic model_clear();
        idx = 0; outstanding = 0; stall = 0; err_exp = 0;
    endtask

    // One clock: check bus rules, drive inputs at negedge, advance the model, return just after posedge.
    task automatic step(input logic rdy, input logic rsp);
        bit f;
        @(negedge clk);
        if (stall) check("stable_while_stalled", {cfg_v_o, bus_pl()}, {1'b1, stall_pl});
        if (cfg_v_o) check("credit_limit", 128'(outstanding < MAXC), 128'(1));
        check("error_flag", 128'(cfg_error_o), 128'(err_exp));
        cfg_ready_i = rdy;
        resp_v_i    = rsp;
        f = cfg_v_o && rdy;
        if (f) begin
            if (idx >= exp_q.size()) begin
                check("extra_write", 128'(idx), 128'(exp_q.size()));
            end else begin
                if (idx == NC * STEPS) check("drained_before_unfreeze", 128'(outstanding), 128'(0));
                check("write_payload", bus_pl(), wr_pl(exp_q[idx]));
            end
            idx++;
            fires++;
        end
        stall    = cfg_v_o && !rdy;
        stall_pl = bus_pl();
        if (rsp) last_rsp_cyc = cyc;
        if (rsp && !f && outstanding == 0) err_exp = 1;
        else outstanding = outstanding + int'(f) - int'(rsp);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, ack every cycle something is outstanding; mode 1: random ready and acks.
    task automatic run_to_done(input int mode, input int budget);
        int   n;
        logic rdy, rsp;
        n = 0;
        while (!done_o && n < budget) begin
            if (mode == 0) begin
                rdy = 1'b1;
                rsp = (outstanding > 0);
            end else begin
                rdy = 1'($urandom_range(0, 1));
                rsp = (outstanding > 0) && ($urandom_range(0, 2) == 0);
            end
            step(rdy, rsp);
            n++;
        end
        check("done_reached", 128'(done_o), 128'(1));
        if (mode == 0) check("done_latency", 128'(cyc - 1), 128'(last_rsp_cyc + 1));
        check("busy_at_done", 128'(busy_o), 128'(0));
        check("write_count", 128'(idx), 128'(TOTAL));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n_i   = 1'b0;
        cfg_ready_i = 1'b0;
        resp_v_i    = 1'b0;
        restart_i   = 1'b0;
        #1;
        check("reset_outputs", 128'({cfg_v_o, busy_o, done_o, cfg_error_o}), 128'(0));
        model_clear();
        @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    initial begin
        int f0, g;
        reset_n_i = 1'b0; restart_i = 1'b0; cfg_ready_i = 1'b0; resp_v_i = 1'b0;
        cyc = 0; fires = 0; last_rsp_cyc = 0;
        build_expected();
        model_clear();

        // Ordered sequence with immediate ready and one-cycle acks.
        apply_reset();
        step(1'b0, 1'b0);
        check("start_busy_valid", 128'({busy_o, cfg_v_o, done_o}), 128'(3'b110));
        run_to_done(0, 300);

        // Credit exhaustion and resume on a single ack.
        apply_reset();
        f0 = fires;
        repeat (6) step(1'b1, 1'b0);
        check("held_fires", 128'(fires - f0), 128'(MAXC));
        check("held_valid", 128'(cfg_v_o), 128'(0));
        step(1'b1, 1'b1);
        check("resume_valid", 128'(cfg_v_o), 128'(1));
        check("resume_payload", bus_pl(), wr_pl(exp_q[MAXC]));
        run_to_done(0, 300);

        // Random backpressure and ack timing.
        apply_reset();
        run_to_done(1, 3000);

        // Stray ack straight after reset, then a full random run.
        apply_reset();
        step(1'b0, 1'b1);
        run_to_done(1, 3000);
        check("error_sticky", 128'(cfg_error_o), 128'(1));

        // Restart from DONE repeats the whole sequence.
        restart_i = 1'b1;
        step(1'b0, 1'b0);
        restart_i = 1'b0;
        check("restart_state", 128'({busy_o, done_o}), 128'(2'b10));
        idx = 0;
        run_to_done(0, 300);

        // Asynchronous reset while core 1 ICACHE write is pending.
        apply_reset();
        g = 0;
        while (idx < STEPS + 2 && g < 200) begin
            step(1'b1, outstanding > 0);
            g++;
        end
        check("reached_core1_icache", 128'(idx), 128'(STEPS + 2));
        #2;
        reset_n_i = 1'b0;
        #1;
        check("async_reset_clear", 128'({cfg_v_o, busy_o, done_o, cfg_error_o}), 128'(0));
        model_clear();
        cfg_ready_i = 1'b0;
        resp_v_i    = 1'b0;
        @(negedge clk);
        reset_n_i = 1'b1;
        run_to_done(0, 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
